// File: rtl/class_sum_acc.sv
// class_sum_acc: per-class ReLU accumulation over a feature map, emitting saturated class sums with a one-cycle valid pulse.
module class_sum_acc #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int N_MATS     = 10,
    parameter int MAP_PIXELS = 16,
    localparam int CNT_W     = $clog2(MAP_PIXELS),
    localparam int ACC_W     = IN_WIDTH + $clog2(MAP_PIXELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [IN_WIDTH-1:0]   pix_in [N_MATS],
    input  logic                         valid_in,
    output logic                         in_ready,
    input  logic                         flush,
    output logic        [DATA_WIDTH-1:0] sum_out [N_MATS],
    output logic                         valid_out,
    output logic                         sat_flag,
    output logic        [CNT_W-1:0]      beat_cnt
);
    typedef enum logic {ACCUM, EMIT} state_t;
    state_t state;
    logic [ACC_W-1:0] acc [N_MATS];
    logic [ACC_W-1:0] nxt [N_MATS];
    logic [DATA_WIDTH-1:0] clamp [N_MATS];
    logic [N_MATS-1:0] sat;
    logic accept, last;
    assign in_ready = state == ACCUM;
    assign accept   = valid_in && in_ready && !flush;
    assign last     = accept && beat_cnt == CNT_W'(MAP_PIXELS - 1);
    genvar c;
    for (c = 0; c < N_MATS; c++) begin : g_ch
        // negative pixels, including the most negative code, contribute nothing
        assign nxt[c] = acc[c] + (pix_in[c][IN_WIDTH-1] ? '0 : ACC_W'($unsigned(pix_in[c])));
        if (DATA_WIDTH < ACC_W) begin : g_sat
            assign sat[c]   = |nxt[c][ACC_W-1:DATA_WIDTH];
            assign clamp[c] = sat[c] ? '1 : nxt[c][DATA_WIDTH-1:0];
        end else begin : g_ext
            assign sat[c]   = 1'b0;
            assign clamp[c] = DATA_WIDTH'(nxt[c]);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            beat_cnt  <= '0;
            valid_out <= 1'b0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < N_MATS; i++) begin
                acc[i]     <= '0;
                sum_out[i] <= '0;
            end
        end else begin
            valid_out <= last;
            if (state == EMIT) begin
                state <= ACCUM;
            end else if (flush) begin
                beat_cnt <= '0;
                for (int i = 0; i < N_MATS; i++) acc[i] <= '0;
            end else if (last) begin
                state    <= EMIT;
                beat_cnt <= '0;
                sat_flag <= |sat;
                for (int i = 0; i < N_MATS; i++) begin
                    sum_out[i] <= clamp[i];
                    acc[i]     <= '0;
                end
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                for (int i = 0; i < N_MATS; i++) acc[i] <= nxt[i];
            end
        end
    end
endmodule
